// File: rtl/hi_lo_multiply_divide_unit_pkg.sv
// rtl/hi_lo_multiply_divide_unit_pkg.sv - shared funct codes, state enum and iteration count for HI/LO ops
package hi_lo_multiply_divide_unit_pkg;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_multi_cycle(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/hi_lo_multiply_divide_unit_if.sv
// rtl/hi_lo_multiply_divide_unit_if.sv - execute-stage request and HI/LO result bundle
interface hi_lo_multiply_divide_unit_if;

    logic        start;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, funct, src_a, src_b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, funct, src_a, src_b,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/hi_lo_sign_fixup.sv
// rtl/hi_lo_sign_fixup.sv - combinational conditional two's-complement negate
module hi_lo_sign_fixup #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/hi_lo_multiply_divide_unit.sv
// rtl/hi_lo_multiply_divide_unit.sv - iterative MULT/MULTU/DIV/DIVU engine owning HI and LO
module hi_lo_multiply_divide_unit
    import hi_lo_multiply_divide_unit_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    hi_lo_multiply_divide_unit_if.slave   bus
);

    state_t      state, state_next;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] operand_b;
    logic [31:0] orig_a;
    logic        sign_a, sign_b, op_div, op_signed, b_zero;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        accept_multi, accept_mthi, accept_mtlo;
    logic        req_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_diff;
    logic [63:0] acc_step, product;
    logic [31:0] quotient, remainder;

    assign req_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);

    hi_lo_sign_fixup #(.WIDTH(32)) u_abs_a (.value(bus.src_a), .negate(req_signed & bus.src_a[31]), .result(mag_a));
    hi_lo_sign_fixup #(.WIDTH(32)) u_abs_b (.value(bus.src_b), .negate(req_signed & bus.src_b[31]), .result(mag_b));
    hi_lo_sign_fixup #(.WIDTH(64)) u_prod  (.value(acc),        .negate(op_signed & (sign_a ^ sign_b)), .result(product));
    hi_lo_sign_fixup #(.WIDTH(32)) u_quot  (.value(acc[31:0]),  .negate(op_signed & (sign_a ^ sign_b)), .result(quotient));
    hi_lo_sign_fixup #(.WIDTH(32)) u_rem   (.value(acc[63:32]), .negate(op_signed & sign_a),            .result(remainder));

    // Multiply: acc = {partial, multiplier} shifted right. Divide: acc = {remainder, quotient} shifted left.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand_b : 32'd0)};
        div_diff = acc[63:31] - {1'b0, operand_b};
        if (!op_div)
            acc_step = {mul_sum, acc[31:1]};
        else if (div_diff[32])
            acc_step = {acc[62:0], 1'b0};
        else
            acc_step = {div_diff[31:0], acc[30:0], 1'b1};
    end

    always_comb begin
        state_next   = state;
        accept_multi = 1'b0;
        accept_mthi  = 1'b0;
        accept_mtlo  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_multi = is_multi_cycle(bus.funct);
                    accept_mthi  = (bus.funct == FUNCT_MTHI);
                    accept_mtlo  = (bus.funct == FUNCT_MTLO);
                    if (accept_multi)
                        state_next = RUN;
                end
            end
            RUN:     if (count == 5'(ITERATIONS - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 5'd0;
            acc       <= 64'd0;
            operand_b <= 32'd0;
            orig_a    <= 32'd0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            b_zero    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == FIX);
            if (accept_multi) begin
                sign_a    <= bus.src_a[31];
                sign_b    <= bus.src_b[31];
                op_signed <= req_signed;
                op_div    <= (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
                b_zero    <= (bus.src_b == 32'd0);
                orig_a    <= bus.src_a;
                operand_b <= mag_b;
                acc       <= {32'd0, mag_a};
                count     <= 5'd0;
            end
            if (state == RUN) begin
                acc   <= acc_step;
                count <= count + 5'd1;
            end
            if (state == FIX) begin
                if (op_div && b_zero) begin
                    hi_q <= orig_a;
                    lo_q <= 32'hFFFF_FFFF;
                end else if (op_div) begin
                    hi_q <= remainder;
                    lo_q <= quotient;
                end else begin
                    {hi_q, lo_q} <= product;
                end
            end
            if (accept_mthi) hi_q <= bus.src_a;
            if (accept_mtlo) lo_q <= bus.src_a;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = done_q;
    assign bus.busy = bus.start | (state != IDLE);

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// tb/tb_hi_lo_multiply_divide_unit.sv - scoreboard bench for the HI/LO multiply/divide unit
module tb_hi_lo_multiply_divide_unit;
    import hi_lo_multiply_divide_unit_pkg::*;

    logic clk;
    logic reset;
    hi_lo_multiply_divide_unit_if bus();

    hi_lo_multiply_divide_unit dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    logic [31:0] exp_hi_q[$];
    logic [31:0] exp_lo_q[$];
    logic [31:0] model_hi, model_lo;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        h  = 32'd0;
        l  = 32'd0;
        case (f)
            FUNCT_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            FUNCT_MULTU: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            FUNCT_DIV:   if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                         else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
            FUNCT_DIVU:  if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                         else begin h = a % b; l = a / b; end
            default: ;
        endcase
    endfunction

    // Called at a falling edge; the op is accepted at the following rising edge (E0).
    task automatic run_multi(input string tag, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                             input bit inject);
        int          n;
        logic [31:0] ph, pl;
        exp_hi_q.push_back(eh);
        exp_lo_q.push_back(el);
        bus.start = 1'b1; bus.funct = f; bus.src_a = a; bus.src_b = b;
        #1;
        check32({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
        n = 1;
        while (!bus.done && n < 40) begin
            if (n == 1) check32({tag, "_done_idle"}, 32'(bus.done), 32'd0);
            if (n == 33) begin
                check32({tag, "_busy_fix"}, 32'(bus.busy), 32'd1);
                check32({tag, "_hi_held"}, bus.hi, model_hi);
            end
            if (inject && n == 5) begin
                bus.start = 1'b1; bus.funct = FUNCT_MTLO; bus.src_a = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check32({tag, "_latency"}, 32'(n), 32'd34);
        check32({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        if (exp_hi_q.size() == 0) begin
            check32({tag, "_scoreboard"}, 32'd0, 32'd1);
        end else begin
            ph = exp_hi_q.pop_front();
            pl = exp_lo_q.pop_front();
            check32({tag, "_hi"}, bus.hi, ph);
            check32({tag, "_lo"}, bus.lo, pl);
            model_hi = ph;
            model_lo = pl;
        end
    endtask

    initial begin
        logic [31:0] rh, rl, ra, rb;
        logic [5:0]  rf;
        int          dones;
        bus.start = 1'b0; bus.funct = 6'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
        model_hi = 32'd0; model_lo = 32'd0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check32("rst_hi", bus.hi, 32'd0);
        check32("rst_lo", bus.lo, 32'd0);
        check32("rst_done", 32'(bus.done), 32'd0);
        check32("rst_busy_low", 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.funct = FUNCT_MTHI;
        #1 check32("rst_busy_start", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_multi("mult_neg", FUNCT_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        @(negedge clk);
        check32("mult_neg_done_pulse", 32'(bus.done), 32'd0);

        run_multi("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        run_multi("div_neg7", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_multi("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_multi("divu_zero", FUNCT_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
        run_multi("div_zero_neg", FUNCT_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0: rf = FUNCT_MULT;
                1: rf = FUNCT_MULTU;
                2: rf = FUNCT_DIV;
                default: rf = FUNCT_DIVU;
            endcase
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            ref_op(rf, ra, rb, rh, rl);
            run_multi($sformatf("rand%0d_f%02h", i, rf), rf, ra, rb, rh, rl, 1'b0);
        end

        @(negedge clk);
        bus.start = 1'b1; bus.funct = FUNCT_MTHI; bus.src_a = 32'h1234_5678;
        #1 check32("mthi_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check32("mthi_hi", bus.hi, 32'h1234_5678);
        check32("mthi_lo", bus.lo, model_lo);
        #1 check32("mthi_busy_after", 32'(bus.busy), 32'd0);
        model_hi = 32'h1234_5678;
        bus.start = 1'b1; bus.funct = FUNCT_MTLO; bus.src_a = 32'hCAFE_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        check32("mtlo_lo", bus.lo, 32'hCAFE_F00D);
        check32("mtlo_hi", bus.hi, model_hi);
        model_lo = 32'hCAFE_F00D;
        bus.start = 1'b1; bus.funct = 6'h20; bus.src_a = 32'h5555_AAAA;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check32("ignored_hi", bus.hi, model_hi);
        check32("ignored_lo", bus.lo, model_lo);
        check32("ignored_busy", 32'(bus.busy), 32'd0);

        @(negedge clk);
        bus.start = 1'b1; bus.funct = FUNCT_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check32("abort_hi", bus.hi, 32'd0);
        check32("abort_lo", bus.lo, 32'd0);
        check32("abort_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.funct = FUNCT_MULT;
        #1 check32("abort_busy_start", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_hi = 32'd0; model_lo = 32'd0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check32("abort_no_done", 32'(dones), 32'd0);
        check32("abort_idle_busy", 32'(bus.busy), 32'd0);

        ref_op(FUNCT_MULT, 32'h7FFF_FFFF, 32'h8000_0000, rh, rl);
        run_multi("mult_after_abort", FUNCT_MULT, 32'h7FFF_FFFF, 32'h8000_0000, rh, rl, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/hi_lo_multiply_divide_unit.md
# hi_lo_multiply_divide_unit

Iterative multiply/divide engine that owns the HI and LO architectural registers. Sits in the execute stage directly downstream of the decode/execute pipeline register. It consumes the execute-stage function code, source operands and HI/LO write controls, and runs MULT/MULTU/DIV/DIVU over multiple cycles. A busy signal goes to the hazard unit, which stalls the pipeline.

## Interface
Parameters:
- none; datapath fixed at 32 bits, 32 iterations.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  execute-stage instruction is a HI/LO writer: the OR of the HI and LO register-write controls.
- funct  in  6  execute-stage ALU function code.
- src_a  in  32  rs operand; already forwarded.
- src_b  in  32  rt operand; already forwarded.
- hi  out  32  current HI register value.
- lo  out  32  current LO register value.
- busy  out  1  combinational: start OR state != IDLE; drives the hazard-unit stall.
- done  out  1  one-cycle pulse in the cycle after HI/LO take a multi-cycle result.

## Operation
- Function codes:
  - MTHI 0x11, MTLO 0x13: single-cycle.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B: multi-cycle.
  - Any other funct with start=1: ignored.
- MTHI/MTLO accepted in IDLE: the written register takes src_a at the same edge. busy is high for that cycle only, from start.
- Multi-cycle op accepted in IDLE:
  - Latch signs.
  - For signed ops, latch magnitudes |src_a|, |src_b|; for unsigned ops, latch raw values.
  - Clear a 5-bit counter and go to RUN.
- RUN performs one radix-2 iteration per cycle, 32 total:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 64-bit remainder:quotient register.
- After counter reaches 31, go to FIX.
- FIX applies sign correction and writes both HI and LO, then returns to IDLE.
- Multiply result: LO = product[31:0], HI = product[63:32]. Product is negated for MULT when sign_a XOR sign_b.
- Divide result: LO = quotient, HI = remainder.
  - Signed quotient sign = sign_a XOR sign_b.
  - Remainder sign = sign_a.
  - All arithmetic wraps modulo 2^32.
- Divide by zero, any divide op: LO = 0xFFFFFFFF, HI = src_a as latched (original signed value, not magnitude).
- DIV 0x80000000 / 0xFFFFFFFF: natural wrap gives LO = 0x80000000, HI = 0. No special case.
- start while RUN/FIX: ignored; operands are not re-latched. The hazard unit guarantees no such start.
- hi/lo outputs change only:
  - at the FIX edge;
  - at an MTHI/MTLO edge;
  - at reset.

## Timing
- Reset values:
  - hi = 0, lo = 0.
  - state = IDLE, counter = 0.
  - done = 0.
  - busy = start.
- State machine:
  - IDLE -> RUN: start with a multi-cycle funct.
  - RUN -> RUN: counter < 31.
  - RUN -> FIX: counter == 31.
  - FIX -> IDLE: unconditional.
- Latency, with the multi-cycle op accepted at edge E0:
  - RUN iterations at edges E1..E32.
  - FIX write at edge E33.
  - done high during cycle E33..E34.
  - busy high from the start cycle through cycle E32..E33.
  - busy low after E33, so an MFHI in the same instruction slot reads the new value.
- done and the updated HI/LO appear together.
- Back-to-back: a new start is accepted in the cycle after FIX, i.e. the cycle where done=1.
- Reset asserted mid-RUN/FIX:
  - Immediate abort to IDLE.
  - hi/lo cleared.
  - No done pulse.

## Structure
- Shared package holds:
  - funct constants: MTHI, MTLO, MULT, MULTU, DIV, DIVU.
  - state enum: IDLE, RUN, FIX.
  - iteration count constant: 32.
- The package is also used by the decoder and the hazard unit.
- Single module; multiply and divide share the 64-bit working register and counter.
- One sub-module: hi_lo_sign_fixup, a combinational conditional two's-complement negate for the 32- and 64-bit results.

## Test plan
- MULT src_a=0xFFFFFFFE, src_b=3:
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA at E33.
  - done high exactly one cycle; busy low from E33.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007.
- MTHI 0x12345678 in IDLE:
  - hi=0x12345678 next edge, lo unchanged.
  - MTLO start during RUN is ignored.
- Reset asserted at E10 of a DIV:
  - hi=lo=0, busy=start, no done pulse.
  - A fresh MULT afterwards completes normally.
